// File: rtl/blur_result_packer.sv
// rtl/blur_result_packer.sv - saturates blur pixels, packs 4 per word, buffers words in a FWFT FIFO
module blur_result_packer #(
    parameter int FRAME_PIXELS = 260100,
    parameter int FIFO_DEPTH   = 8,
    parameter int SAT_MAX      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] i_data,
    input  logic        i_en,
    output logic [31:0] o_data,
    output logic        o_last,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        frame_done,
    output logic        overflow,
    output logic [17:0] pix_count
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [17:0] LAST_PIX = 18'(FRAME_PIXELS - 1);
    localparam logic [19:0] SAT_LIM  = 20'(SAT_MAX);
    localparam logic [7:0]  SAT_VAL  = 8'(SAT_MAX);

    logic [23:0] acc;
    logic [1:0]  lane;
    logic [7:0]  pix;
    logic        eof;
    logic        complete;
    logic [31:0] word;

    logic [32:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;

    always_comb begin
        pix      = (i_data > SAT_LIM) ? SAT_VAL : i_data[7:0];
        eof      = i_en && (pix_count == LAST_PIX);
        complete = i_en && ((lane == 2'd3) || eof);
        // Accumulator lanes above the current one are always zero, so OR-ing
        // the new pixel in also yields the zero-padded partial word at frame end.
        word     = {8'd0, acc} | ({24'd0, pix} << {lane, 3'b000});
    end

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = !empty && o_ready;
        push  = complete && (!full || pop);
    end

    assign o_valid = !empty;
    assign o_data  = mem[rd_ptr[AW-1:0]][31:0];
    assign o_last  = mem[rd_ptr[AW-1:0]][32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            lane       <= '0;
            pix_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= eof;
            if (complete) begin
                acc  <= '0;
                lane <= '0;
            end else if (i_en) begin
                acc  <= word[23:0];
                lane <= lane + 2'd1;
            end
            if (eof) begin
                pix_count <= '0;
            end else if (i_en) begin
                pix_count <= pix_count + 18'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {eof, word};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A drop only happens when the FIFO is full and nothing leaves this cycle.
            if (complete && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/blur_result_packer.md
# blur_result_packer

Downstream stage of the 3x3 blur engine. Takes the engine's 20-bit filtered-pixel stream (`i_data` qualified by single-cycle `i_en` pulses, no backpressure), saturates each sample to 8 bits, and packs four pixels per 32-bit word. Packed words are buffered in a small FIFO and drained over a valid/ready port. The block also tracks frame boundaries and flags any data loss.

## Interface
- `FRAME_PIXELS`, 260100: filtered pixels per frame, 510x510 interior.
- `FIFO_DEPTH`, 8: word FIFO depth; power of two, at least 2.
- `SAT_MAX`, 255: saturation ceiling applied to each input sample.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `i_data` input 20: filtered pixel from the blur engine.
- `i_en` input 1: `i_data` valid this cycle; cannot be stalled.
- `o_data` output 32: packed word. Pixel k is in bits [8k+7:8k], first pixel in [7:0].
- `o_last` output 1: qualifies `o_data` as the final word of a frame.
- `o_valid` output 1: FIFO head is valid.
- `o_ready` input 1: consumer accepts head when `o_valid` and `o_ready` are both high.
- `frame_done` output 1: one-cycle pulse after the final pixel of a frame is taken.
- `overflow` output 1: sticky; a word was dropped because the FIFO was full.
- `pix_count` output 18: pixels taken in the current frame.

## Operation
- Saturation: pixel = (`i_data` > `SAT_MAX`) ? `SAT_MAX`[7:0] : `i_data`[7:0].
- Pack register: 24-bit accumulator plus a 2-bit lane index `lane` (0..3). Each `i_en` cycle writes the pixel into the current lane and increments `lane`.
- Word completion happens when `lane`==3, or when `pix_count`==`FRAME_PIXELS`-1 (end of frame).
  - The word is formed combinationally from the accumulator and the current pixel.
  - Unused upper lanes are zero.
  - `o_last` = end of frame.
  - On the same edge, the word is pushed to the FIFO, `lane` clears to 0 and the accumulator clears.
- `pix_count` increments on each `i_en`. On the end-of-frame pixel it wraps to 0 and `frame_done` pulses on the next cycle.
- FIFO:
  - 33 bits wide (data plus last flag), first-word-fall-through.
  - `o_valid` = not empty; `o_data`/`o_last` = head entry.
  - Pop when `o_valid && o_ready`.
- Push while full:
  - With a simultaneous pop, the push succeeds and occupancy is unchanged.
  - Without a pop, the word is dropped and `overflow` sets.
  - Packing and `pix_count` continue normally in both cases.
- Pop while empty has no effect.
- `overflow` clears only on reset.
- `i_en` with `o_ready` low never stalls the input side.

## Timing
- Reset (`rst`=0, asynchronous):
  - Outputs: `o_valid`=0, `o_data`=0, `o_last`=0, `frame_done`=0, `overflow`=0, `pix_count`=0.
  - Internal: `lane`=0, FIFO empty, accumulator=0.
- Reset asserted mid-frame or mid-word discards the partial word and all FIFO contents. Counting restarts at pixel 0 after release.
- Latency: the completing pixel sampled at edge N gives `o_valid`=1 after edge N, provided the FIFO was empty.
- Throughput: one `i_en` per cycle sustained. One word every 4 cycles worst case, so the consumer must average at least 1 pop per 4 cycles.
- `frame_done` is high for exactly one cycle, the cycle after the edge that took the final pixel.
- With the default `FRAME_PIXELS`, a frame is 65025 words and no partial word occurs. A non-multiple-of-4 setting gives one zero-padded final word.
- `o_data` and `o_last` stay stable while `o_valid`=1 and `o_ready`=0.

## Test plan
- Saturation and order: `i_en` on 4 consecutive cycles with `i_data`=0x00012, 0x000FF, 0x00100, 0xFFFFF, `o_ready`=1 → one word 0xFFFFFF12, `o_last`=0, `o_valid` high for 1 cycle after the 4th pixel edge.
- Frame end:
  - `FRAME_PIXELS`=6, pixels 1..6, `o_ready`=1 → words 0x04030201 (`o_last`=0) then 0x00000605 (`o_last`=1).
  - `frame_done` pulses 1 cycle after pixel 6.
  - `pix_count` returns to 0.
- Backpressure and overflow:
  - `o_ready`=0, 36 consecutive pixels → FIFO holds 8 words, 9th word dropped, `overflow`=1.
  - Then `o_ready`=1 → exactly 8 words drain in order, `overflow` stays 1.
- Full with simultaneous pop: FIFO full, 4th pixel edge coincides with a pop → new word accepted, `overflow` stays 0, occupancy stays 8.
- Reset mid-word:
  - 2 pixels, then `rst` low 1 cycle → `o_valid`=0 and `pix_count`=0.
  - Next 4 pixels 0xA,0xB,0xC,0xD → 0x0D0C0B0A.
- Sustained default frame: 260100 pixels at one per cycle, `o_ready` toggling 50% → 65025 words, only the last has `o_last`=1, one `frame_done`, `overflow`=0.
